// File: rtl/float_to_int16_if.sv
// Handshake bundle for float_to_int16: float sample in, saturated int16 result out.
// master = upstream/downstream side, slave = the converter.
interface float_to_int16_if;
  logic [31:0] float_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] int_out;
  logic        out_ovf;
  logic        out_nan;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output float_in, in_valid, out_ready,
    input  in_ready, int_out, out_ovf, out_nan, out_valid
  );

  modport slave (
    input  float_in, in_valid, out_ready,
    output in_ready, int_out, out_ovf, out_nan, out_valid
  );
endinterface

// File: rtl/float_to_int16.sv
// IEEE-754 single to saturating int16 via an iterative right-shifter (SHIFT_STEP bits/cycle).
// Define FLOAT_TO_INT16_ROUND_EN for round-to-nearest-even; the default build truncates toward zero.
module float_to_int16 #(
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            resetn,
  float_to_int16_if.slave io
);
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;

  state_t               state_q;
  logic                 sign_q, guard_q, sticky_q, force_ovf_q, pend_nan_q;
  logic [23:0]          sig_q;
  logic [4:0]           cnt_q;
  logic [15:0]          int_q;
  logic                 ovf_q, nan_q, vld_q;

  logic [7:0]           exp_w;
  logic [22:0]          frac_w;
  logic [23:0]          ld_sig_d, lo_mask_d, sig_d;
  logic [4:0]           ld_cnt_d, n_d, cnt_d;
  logic                 ld_special_d, ld_force_d, ld_nan_d, guard_d, sticky_d;
  logic [16:0]          mag_d;
  logic signed [15:0]   res_d;
  logic                 ovf_d, nan_d;

  function automatic logic round_inc(input logic guard, input logic sticky, input logic lsb);
`ifdef FLOAT_TO_INT16_ROUND_EN
    return guard & (sticky | lsb);
`else
    return 1'b0 & (guard | sticky | lsb);
`endif
  endfunction

  // Magnitude >= 32768: positive clips with overflow, negative lands exactly on -32768.
  function automatic logic signed [15:0] saturate(input logic sign, input logic [16:0] mag);
    if (mag >= 17'd32768) return sign ? 16'sh8000 : 16'sh7FFF;
    else if (sign)        return 16'(~mag[15:0] + 16'd1);
    else                  return mag[15:0];
  endfunction

  assign exp_w  = io.float_in[30:23];
  assign frac_w = io.float_in[22:0];

  always_comb begin
    ld_sig_d     = {1'b1, frac_w};
    ld_cnt_d     = 5'(8'd150 - exp_w);
    ld_special_d = 1'b0;
    ld_force_d   = 1'b0;
    ld_nan_d     = 1'b0;
    if (exp_w == 8'hFF) begin
      ld_special_d = 1'b1;
      ld_sig_d     = '0;
      ld_nan_d     = |frac_w;
      ld_force_d   = ~|frac_w;
    end else if (exp_w <= 8'd125) begin
      ld_special_d = 1'b1;
      ld_sig_d     = '0;
    end else if (exp_w >= 8'd142) begin
      // -32768.0 exactly is representable, everything else at this exponent clips
      ld_special_d = 1'b1;
      ld_sig_d     = 24'h008000;
      ld_force_d   = !(io.float_in[31] && exp_w == 8'd142 && frac_w == '0);
    end
  end

  always_comb begin
    n_d       = (cnt_q < 5'(SHIFT_STEP)) ? cnt_q : 5'(SHIFT_STEP);
    lo_mask_d = (24'd1 << (n_d - 5'd1)) - 24'd1;
    sig_d     = sig_q >> n_d;
    guard_d   = sig_q[n_d - 5'd1];
    sticky_d  = sticky_q | guard_q | (|(sig_q & lo_mask_d));
    cnt_d     = cnt_q - n_d;
  end

  always_comb begin
    mag_d = {1'b0, sig_q[15:0]} + {16'd0, round_inc(guard_q, sticky_q, sig_q[0])};
    res_d = saturate(sign_q, mag_d);
    ovf_d = !sign_q && (mag_d >= 17'd32768);
    nan_d = 1'b0;
    if (pend_nan_q) begin
      res_d = '0;
      ovf_d = 1'b0;
      nan_d = 1'b1;
    end else if (force_ovf_q) begin
      res_d = sign_q ? 16'sh8000 : 16'sh7FFF;
      ovf_d = 1'b1;
    end
  end

  // control and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      int_q   <= '0;
      ovf_q   <= 1'b0;
      nan_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (io.in_valid) state_q <= ld_special_d ? ROUND : SHIFT;
        SHIFT: if (cnt_d == 5'd0) state_q <= ROUND;
        ROUND: begin
          int_q   <= res_d;
          ovf_q   <= ovf_d;
          nan_q   <= nan_d;
          vld_q   <= 1'b1;
          state_q <= OUT;
        end
        OUT: if (io.out_ready) begin
          vld_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // datapath registers, only meaningful once loaded on accept
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: if (io.in_valid) begin
        sign_q      <= io.float_in[31];
        sig_q       <= ld_sig_d;
        cnt_q       <= ld_cnt_d;
        guard_q     <= 1'b0;
        sticky_q    <= 1'b0;
        force_ovf_q <= ld_force_d;
        pend_nan_q  <= ld_nan_d;
      end
      SHIFT: begin
        sig_q    <= sig_d;
        cnt_q    <= cnt_d;
        guard_q  <= guard_d;
        sticky_q <= sticky_d;
      end
      default: ;
    endcase
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.int_out   = int_q;
  assign io.out_ovf   = ovf_q;
  assign io.out_nan   = nan_q;
  assign io.out_valid = vld_q;
endmodule

// File: tb/tb_float_to_int16.sv
// Bench for float_to_int16: three instances (SHIFT_STEP 4, 1, 8), directed vectors from the
// test plan plus random floats checked against a fixed-point arithmetic reference.
module tb_float_to_int16;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] fin  [3];
  logic        iv   [3];
  logic        ordy [3];
  logic        irdy [3];
  logic        ovld [3];
  logic        oovf [3];
  logic        onan [3];
  logic [15:0] iout [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    float_to_int16_if bus ();
    assign bus.float_in  = fin[g];
    assign bus.in_valid  = iv[g];
    assign bus.out_ready = ordy[g];
    assign irdy[g] = bus.in_ready;
    assign ovld[g] = bus.out_valid;
    assign oovf[g] = bus.out_ovf;
    assign onan[g] = bus.out_nan;
    assign iout[g] = bus.int_out;
    float_to_int16 #(.SHIFT_STEP(g == 0 ? 4 : (g == 1 ? 1 : 8))) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .io     (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int step_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
  endfunction

  function automatic int exp_lat(input logic [31:0] f, input int step);
    int ex = int'(f[30:23]);
    int e  = ex - 127;
    if (ex == 255 || ex == 0 || e >= 15 || e <= -2) return 1;
    return (23 - e + step - 1) / step + 1;
  endfunction

  // Value held as unsigned fixed point with 24 fractional bits, then rounded and clipped.
  function automatic void model(input logic [31:0] f, output logic [15:0] r,
                                output logic o, output logic n);
    logic        s  = f[31];
    int          ex = int'(f[30:23]);
    int          e  = ex - 127;
    logic [63:0] sig, fx, ip;
    logic [23:0] fr;
    r = '0; o = 1'b0; n = 1'b0;
    if (ex == 255) begin
      if (f[22:0] != '0) n = 1'b1;
      else begin o = 1'b1; r = s ? 16'h8000 : 16'h7FFF; end
      return;
    end
    if (ex == 0) return;
    sig = {40'd0, 1'b1, f[22:0]};
    if (e > 39)       fx = '1;
    else if (e >= -1) fx = sig << (e + 1);
    else              fx = '0;
    ip = fx >> 24;
    fr = fx[23:0];
`ifdef FLOAT_TO_INT16_ROUND_EN
    if (fr > 24'h800000 || (fr == 24'h800000 && ip[0])) ip = ip + 64'd1;
`endif
    if (!s) begin
      if (ip >= 64'd32768) begin r = 16'h7FFF; o = 1'b1; end
      else r = ip[15:0];
    end else begin
      if (fx > (64'd32768 << 24)) begin r = 16'h8000; o = 1'b1; end
      else if (ip >= 64'd32768) r = 16'h8000;
      else r = 16'(-ip[15:0]);
    end
  endfunction

  // One transaction on lane d; out_ready held low for 'hold' cycles once out_valid is seen.
  task automatic xact(input int d, input logic [31:0] f, input int hold,
                      output logic [15:0] r, output logic o, output logic n);
    int k = 0;
    int lat = 0;
    @(negedge clk);
    while (!irdy[d] && k < 60) begin @(negedge clk); k++; end
    chk("in_ready_wait", 32'(irdy[d]), 32'd1);
    fin[d]  = f;
    iv[d]   = 1'b1;
    ordy[d] = (hold == 0);
    @(posedge clk); #1;
    iv[d] = 1'b0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ovld[d]) break;
    end
    chk("out_valid_seen", 32'(ovld[d]), 32'd1);
    chk($sformatf("latency_%0h_s%0d", f, step_of(d)), 32'(lat), 32'(exp_lat(f, step_of(d))));
    r = iout[d]; o = oovf[d]; n = onan[d];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_int_out", {16'd0, iout[d]}, {16'd0, r});
      chk("hold_in_ready", 32'(irdy[d]), 32'd0);
      chk("hold_out_valid", 32'(ovld[d]), 32'd1);
    end
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_valid", 32'(ovld[d]), 32'd0);
    chk("post_hs_ready", 32'(irdy[d]), 32'd1);
  endtask

  task automatic dir(input int d, input logic [31:0] f, input int hold,
                     input logic [15:0] er, input logic eo, input logic en);
    logic [15:0] r;
    logic o, n;
    xact(d, f, hold, r, o, n);
    chk($sformatf("res_%0h", f), {16'd0, r}, {16'd0, er});
    chk($sformatf("ovf_%0h", f), 32'(o), 32'(eo));
    chk($sformatf("nan_%0h", f), 32'(n), 32'(en));
  endtask

  task automatic rnd(input int d);
    logic [31:0] f;
    logic [15:0] r, er;
    logic o, n, eo, en;
    int pick = int'($urandom_range(0, 9));
    f = $urandom;
    if (pick < 7)       f[30:23] = 8'($urandom_range(118, 146));
    else if (pick == 7) f[30:23] = 8'($urandom_range(0, 1) ? 255 : 0);
    if ($urandom_range(0, 7) == 0) f[22:0] = 23'($urandom_range(0, 3)) << 21;
    model(f, er, eo, en);
    xact(d, f, int'($urandom_range(0, 2)), r, o, n);
    chk($sformatf("rand_res_%0h", f), {16'd0, r}, {16'd0, er});
    chk($sformatf("rand_ovf_%0h", f), 32'(o), 32'(eo));
    chk($sformatf("rand_nan_%0h", f), 32'(n), 32'(en));
  endtask

  initial begin
    int seen;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin fin[i] = '0; iv[i] = 1'b0; ordy[i] = 1'b1; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", 32'(ovld[i]), 32'd0);
      chk("rst_ready", 32'(irdy[i]), 32'd1);
      chk("rst_int", {16'd0, iout[i]}, 32'd0);
      chk("rst_flags", {30'd0, oovf[i], onan[i]}, 32'd0);
    end

`ifdef FLOAT_TO_INT16_ROUND_EN
    dir(0, 32'h3FC00000, 0, 16'h0002, 1'b0, 1'b0);
    dir(0, 32'hBFC00000, 0, 16'hFFFE, 1'b0, 1'b0);
    dir(0, 32'h46FFFFFF, 0, 16'h7FFF, 1'b1, 1'b0);
    dir(0, 32'h3F000000, 0, 16'h0000, 1'b0, 1'b0);
`else
    dir(0, 32'h3FC00000, 0, 16'h0001, 1'b0, 1'b0);
    dir(0, 32'hBFC00000, 0, 16'hFFFF, 1'b0, 1'b0);
    dir(0, 32'h46FFFFFF, 0, 16'h7FFF, 1'b0, 1'b0);
    dir(0, 32'h3F000000, 0, 16'h0000, 1'b0, 1'b0);
`endif
    dir(0, 32'h40200000, 0, 16'h0002, 1'b0, 1'b0);
    dir(0, 32'hC7000000, 0, 16'h8000, 1'b0, 1'b0);
    dir(0, 32'h47000000, 0, 16'h7FFF, 1'b1, 1'b0);
    dir(0, 32'h7FC00000, 0, 16'h0000, 1'b0, 1'b1);
    dir(0, 32'hFF800000, 0, 16'h8000, 1'b1, 1'b0);
    dir(0, 32'h7F800000, 0, 16'h7FFF, 1'b1, 1'b0);
    dir(0, 32'h80000000, 0, 16'h0000, 1'b0, 1'b0);
    dir(0, 32'h3E800000, 0, 16'h0000, 1'b0, 1'b0);
    dir(0, 32'hC7000100, 0, 16'h8000, 1'b1, 1'b0);
    dir(0, 32'h3F800000, 5, 16'h0001, 1'b0, 1'b0);
    dir(1, 32'h3F800000, 0, 16'h0001, 1'b0, 1'b0);
    dir(2, 32'h3F800000, 0, 16'h0001, 1'b0, 1'b0);

    // reset pulsed mid-SHIFT discards the sample
    @(negedge clk);
    fin[0] = 32'h3F800000; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midshift_rst_valid", 32'(ovld[0]), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("midshift_rst_ready", 32'(irdy[0]), 32'd1);
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (ovld[0]) seen = 1; end
    chk("no_stale_output", 32'(seen), 32'd0);
    dir(0, 32'h42280000, 0, 16'h002A, 1'b0, 1'b0);

    // reset while a result waits in OUT
    @(negedge clk);
    fin[2] = 32'h7FC00000; iv[2] = 1'b1; ordy[2] = 1'b0;
    @(posedge clk); #1;
    iv[2] = 1'b0;
    @(posedge clk); #1;
    chk("out_state_valid", 32'(ovld[2]), 32'd1);
    resetn = 1'b0;
    #1;
    chk("out_rst_valid", 32'(ovld[2]), 32'd0);
    chk("out_rst_nan", 32'(onan[2]), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    ordy[2] = 1'b1;

    for (int i = 0; i < 150; i++) rnd(0);
    for (int i = 0; i < 30; i++)  rnd(1);
    for (int i = 0; i < 40; i++)  rnd(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
